// File: rtl/line_mem_responder.sv
// line_mem_responder: line-granular main-memory model behind a cache.
// Serves one whole line per read or write request and completes it with a
// one-cycle grant pulse after a fixed, per-direction latency. Also counts
// completed reads, completed writes and abandoned requests.
module line_mem_responder #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 8,
  parameter int RD_LATENCY    = 8,
  parameter int WR_LATENCY    = 8,
  localparam int LINE_SIZE    = 1 << LINE_ADDR_LEN
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [ADDR_LEN-1:0] i_addr,
  input  logic                i_rd_req,
  input  logic                i_wr_req,
  input  logic [31:0]         i_wr_line [LINE_SIZE],
  output logic [31:0]         o_rd_line [LINE_SIZE],
  output logic                o_gnt,
  output logic                o_busy,
  output logic [31:0]         o_rd_cnt,
  output logic [31:0]         o_wr_cnt,
  output logic [31:0]         o_abort_cnt
);

  localparam int DEPTH = 1 << ADDR_LEN;

  // Latency counters are loaded with LAT-1; the extra cycle is the BUSY
  // cycle in which the counter reaches zero, so gnt lands LAT cycles after
  // the accepting edge even when LAT is 1.
  localparam logic [7:0] RD_LOAD = 8'(RD_LATENCY - 1);
  localparam logic [7:0] WR_LOAD = 8'(WR_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_GNT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                r_is_wr;
  logic [ADDR_LEN-1:0] r_addr;
  logic [31:0]         r_wline [LINE_SIZE];
  logic [7:0]          r_cnt;

  // The backing store is deliberately outside reset so lines survive rst.
  logic [31:0] r_mem [DEPTH][LINE_SIZE] = '{default: '0};

  logic w_accept;
  logic w_accept_wr;
  logic w_abort;
  logic w_req_held;

  // State register; reset drops any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus handshake outputs; write wins a simultaneous request.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_accept_wr = 1'b0;
    w_abort     = 1'b0;
    w_req_held  = r_is_wr ? i_wr_req : i_rd_req;
    o_gnt       = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_wr_req || i_rd_req) begin
          w_accept    = 1'b1;
          w_accept_wr = i_wr_req;
          w_next      = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!w_req_held) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_cnt == 8'd0) begin
          w_next = S_GNT;
        end
      end
      S_GNT: begin
        o_gnt  = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request latching, latency countdown, read data capture and statistics.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_is_wr     <= 1'b0;
      r_addr      <= '0;
      r_cnt       <= '0;
      o_rd_cnt    <= '0;
      o_wr_cnt    <= '0;
      o_abort_cnt <= '0;
      for (int i = 0; i < LINE_SIZE; i++) begin
        r_wline[i]   <= '0;
        o_rd_line[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_wr <= w_accept_wr;
            r_addr  <= i_addr;
            r_cnt   <= w_accept_wr ? WR_LOAD : RD_LOAD;
            if (w_accept_wr) begin
              r_wline <= i_wr_line;
            end
          end
        end
        S_BUSY: begin
          if (w_abort) begin
            o_abort_cnt <= o_abort_cnt + 32'd1;
          end else if (r_cnt == 8'd0) begin
            if (!r_is_wr) begin
              o_rd_line <= r_mem[r_addr];
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_GNT: begin
          if (r_is_wr) begin
            o_wr_cnt <= o_wr_cnt + 32'd1;
          end else begin
            o_rd_cnt <= o_rd_cnt + 32'd1;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Commit a granted write on the edge leaving GNT, ahead of any next acceptance.
  always_ff @(posedge i_clk) begin
    if (!i_rst && r_state == S_GNT && r_is_wr) begin
      r_mem[r_addr] <= r_wline;
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: a default-latency instance and a
// second instance with read latency 1, sharing clock and reset.
module tb_line_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [7:0]  addr = '0;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [31:0] wr_line [8];
  logic [31:0] rd_line [8];
  logic        gnt, busy;
  logic [31:0] rd_cnt, wr_cnt, abort_cnt;

  logic [7:0]  addr1 = '0;
  logic        rd_req1 = 1'b0;
  logic        wr_req1 = 1'b0;
  logic [31:0] wr_line1 [8];
  logic [31:0] rd_line1 [8];
  logic        gnt1, busy1;
  logic [31:0] rd_cnt1, wr_cnt1, abort_cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  line_mem_responder u_dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_rd_req(rd_req),
    .i_wr_req(wr_req), .i_wr_line(wr_line), .o_rd_line(rd_line),
    .o_gnt(gnt), .o_busy(busy), .o_rd_cnt(rd_cnt), .o_wr_cnt(wr_cnt),
    .o_abort_cnt(abort_cnt)
  );

  line_mem_responder #(.RD_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_addr(addr1), .i_rd_req(rd_req1),
    .i_wr_req(wr_req1), .i_wr_line(wr_line1), .o_rd_line(rd_line1),
    .o_gnt(gnt1), .o_busy(busy1), .o_rd_cnt(rd_cnt1), .o_wr_cnt(wr_cnt1),
    .o_abort_cnt(abort_cnt1)
  );

  always #5 clk = ~clk;

  // Number of words in a line that differ from base, base+1, ... base+7.
  function automatic int line_errs(input logic [31:0] l [8], input logic [31:0] base);
    int e = 0;
    for (int i = 0; i < 8; i++) begin
      if (l[i] !== base + 32'(i)) e++;
    end
    return e;
  endfunction

  // Counts negedges until the selected grant is seen; -1 if it never comes.
  task automatic wait_gnt(input bit use1, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if ((use1 ? gnt1 : gnt) === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    rd_req = 1'b0; wr_req = 1'b0; rd_req1 = 1'b0; wr_req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_line(input logic [31:0] base);
    for (int i = 0; i < 8; i++) wr_line[i] = base + 32'(i);
  endtask

  // Full write on the default instance; leaves the bench at the grant negedge.
  task automatic do_write(input logic [7:0] a, input logic [31:0] base, output int n);
    addr = a;
    set_line(base);
    wr_req = 1'b1;
    wait_gnt(1'b0, 40, n);
    wr_req = 1'b0;
  endtask

  task automatic test_reset();
    int z;
    apply_reset();
    z = 0;
    for (int i = 0; i < 8; i++) if (rd_line[i] !== 32'd0) z++;
    n_checks++;
    if (gnt !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: gnt=%b busy=%b, required 0 0", gnt, busy);
    end
    n_checks++;
    if (z !== 0) begin
      n_fail++;
      $display("[TB] FAIL reset_rd_line: %0d nonzero words, required 0", z);
    end
    n_checks++;
    if (rd_cnt !== 0 || wr_cnt !== 0 || abort_cnt !== 0) begin
      n_fail++;
      $display("[TB] FAIL reset_cnt: rd=%0d wr=%0d ab=%0d, required 0 0 0", rd_cnt, wr_cnt, abort_cnt);
    end
  endtask

  task automatic test_read();
    int n, bad;
    apply_reset();
    do_write(8'd5, 32'h50, n);
    n_checks++;
    if (n !== 9) begin
      n_fail++;
      $display("[TB] FAIL preload_lat: gnt at step %0d, required 9", n);
    end
    @(negedge clk);
    addr = 8'd5;
    rd_req = 1'b1;
    @(negedge clk);
    addr = 8'd9;
    wait_gnt(1'b0, 40, n);
    if (n > 0) n = n + 1;
    n_checks++;
    if (n !== 9) begin
      n_fail++;
      $display("[TB] FAIL read_lat: gnt at step %0d, required 9", n);
    end
    n_checks++;
    if (line_errs(rd_line, 32'h50) !== 0) begin
      n_fail++;
      $display("[TB] FAIL read_data: word0=%h, required 00000050..57", rd_line[0]);
    end
    rd_req = 1'b0;
    addr = 8'h77;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (line_errs(rd_line, 32'h50) !== 0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("[TB] FAIL read_hold: %0d unstable cycles, required 0", bad);
    end
    n_checks++;
    if (rd_cnt !== 32'd1 || wr_cnt !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL read_cnt: rd=%0d wr=%0d, required 1 1", rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    apply_reset();
    addr = 8'h12;
    set_line(32'hA0);
    wr_req = 1'b1;
    @(negedge clk);
    addr = 8'h13;
    set_line(32'hF0);
    wait_gnt(1'b0, 40, n);
    if (n > 0) n = n + 1;
    n_checks++;
    if (n !== 9) begin
      n_fail++;
      $display("[TB] FAIL b2b_wr_lat: gnt at step %0d, required 9", n);
    end
    // Read raised during the write grant: ignored in GNT, accepted at the end
    // of the following IDLE cycle, so the second grant is RD_LATENCY+2 later.
    wr_req = 1'b0;
    addr = 8'h12;
    rd_req = 1'b1;
    wait_gnt(1'b0, 40, n);
    n_checks++;
    if (n !== 10) begin
      n_fail++;
      $display("[TB] FAIL b2b_gap: second gnt %0d cycles later, required 10", n);
    end
    n_checks++;
    if (line_errs(rd_line, 32'hA0) !== 0) begin
      n_fail++;
      $display("[TB] FAIL b2b_data: word0=%h, required 000000a0..a7", rd_line[0]);
    end
    rd_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rd_cnt !== 32'd1 || wr_cnt !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL b2b_cnt: rd=%0d wr=%0d, required 1 1", rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_abort();
    int n, early;
    apply_reset();
    addr = 8'd5;
    rd_req = 1'b1;
    early = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || gnt !== 1'b0) early++;
    end
    rd_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (early !== 0 || busy !== 1'b0 || gnt !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_busy: bad=%0d busy=%b gnt=%b, required 0 0 0", early, busy, gnt);
    end
    n_checks++;
    if (abort_cnt !== 32'd1 || rd_cnt !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL abort_cnt: ab=%0d rd=%0d, required 1 0", abort_cnt, rd_cnt);
    end
    n_checks++;
    if (rd_line[0] !== 32'd0 || rd_line[7] !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL abort_rd_line: w0=%h w7=%h, required 0 0", rd_line[0], rd_line[7]);
    end
    rd_req = 1'b1;
    wait_gnt(1'b0, 40, n);
    rd_req = 1'b0;
    n_checks++;
    if (n !== 9 || line_errs(rd_line, 32'h50) !== 0) begin
      n_fail++;
      $display("[TB] FAIL abort_next_read: step %0d word0=%h, required 9 00000050", n, rd_line[0]);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    apply_reset();
    addr = 8'd3;
    set_line(32'h30);
    wr_req = 1'b1;
    rd_req = 1'b1;
    wait_gnt(1'b0, 40, n);
    n_checks++;
    if (n !== 9 || rd_cnt !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL simul_wr_first: step %0d rd_cnt %0d, required 9 0", n, rd_cnt);
    end
    wr_req = 1'b0;
    wait_gnt(1'b0, 40, n);
    rd_req = 1'b0;
    n_checks++;
    if (n !== 10 || line_errs(rd_line, 32'h30) !== 0) begin
      n_fail++;
      $display("[TB] FAIL simul_read: gap %0d word0=%h, required 10 00000030", n, rd_line[0]);
    end
    @(negedge clk);
    n_checks++;
    if (rd_cnt !== 32'd1 || wr_cnt !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL simul_cnt: rd=%0d wr=%0d, required 1 1", rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_rd_lat1();
    int n;
    apply_reset();
    addr1 = 8'd7;
    for (int i = 0; i < 8; i++) wr_line1[i] = 32'h70 + 32'(i);
    wr_req1 = 1'b1;
    wait_gnt(1'b1, 40, n);
    wr_req1 = 1'b0;
    n_checks++;
    if (n !== 9) begin
      n_fail++;
      $display("[TB] FAIL lat1_write: gnt at step %0d, required 9", n);
    end
    @(negedge clk);
    rd_req1 = 1'b1;
    wait_gnt(1'b1, 20, n);
    n_checks++;
    if (n !== 2 || line_errs(rd_line1, 32'h70) !== 0) begin
      n_fail++;
      $display("[TB] FAIL lat1_read: step %0d word0=%h, required 2 00000070", n, rd_line1[0]);
    end
    @(negedge clk);
    n_checks++;
    if (gnt1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL lat1_no_reaccept: gnt=%b busy=%b, required 0 0", gnt1, busy1);
    end
    rd_req1 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rd_cnt1 !== 32'd1 || busy1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL lat1_cnt: rd=%0d busy=%b, required 1 0", rd_cnt1, busy1);
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    apply_reset();
    addr = 8'd5;
    set_line(32'hE0);
    wr_req = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr_req = 1'b0;
    n_checks++;
    if (gnt !== 1'b0 || busy !== 1'b0 || wr_cnt !== 0 || rd_cnt !== 0 || abort_cnt !== 0) begin
      n_fail++;
      $display("[TB] FAIL midrst_state: gnt=%b busy=%b wr=%0d rd=%0d ab=%0d, required all 0",
               gnt, busy, wr_cnt, rd_cnt, abort_cnt);
    end
    rd_req = 1'b1;
    wait_gnt(1'b0, 40, n);
    rd_req = 1'b0;
    n_checks++;
    if (n !== 9 || line_errs(rd_line, 32'h50) !== 0) begin
      n_fail++;
      $display("[TB] FAIL midrst_old_data: step %0d word0=%h, required 9 00000050", n, rd_line[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      wr_line[i]  = '0;
      wr_line1[i] = '0;
    end
    test_reset();
    test_read();
    test_back_to_back();
    test_abort();
    test_simultaneous();
    test_rd_lat1();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
